hydra_axis_rr_arbiter: RTL and testbench

- N-to-1 AXI-Stream arbiter that shares one hydra_axis link (axis_req_s / axis_resp_s, 32-bit message) among NUM_REQ requesters.
- Round-robin arbitration with packet locking: a grant is held from the first beat to the tlast beat, so packets never interleave.
- One registered output stage.
- Optional source tagging: the winning requester index is written into t.id.
- Sits in front of shared message/mailbox sinks on the SNOC side.

---
 rtl/hydra_axis_rr_arbiter.sv | 113 +++++++++++
 tb/tb_hydra_axis_rr_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hydra_axis_rr_arbiter.sv
// Round-robin N-to-1 hydra_axis arbiter with packet locking and a registered output stage.
// Per-port bus layout (62 bits): {data[31:0], keep[3:0], last, id[7:0], dest[7:0], user[7:0], tvalid}.
module hydra_axis_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_ID  = 1,
  localparam int IDXW   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ*62-1:0] s_axis_req_i,
  output logic [NUM_REQ-1:0]    s_axis_resp_o,
  output logic [61:0]           m_axis_req_o,
  input  logic                  m_axis_resp_i,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic                  locked_o
);

  localparam int BUSW = 62;
  localparam int TW   = 61;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      r_state;
  logic [IDXW-1:0] r_rr_ptr;
  logic [IDXW-1:0] r_owner;
  logic            r_out_valid;
  logic [TW-1:0]   r_out_t;

  logic [NUM_REQ-1:0] w_valid;
  logic [TW-1:0]      w_t [NUM_REQ];
  logic               w_space;
  logic               w_found;
  logic [IDXW-1:0]    w_winner;
  logic [IDXW-1:0]    w_sel;
  logic [IDXW-1:0]    w_sel_next;
  logic               w_sel_valid;
  logic               w_gnt_any;
  logic               w_accept;
  logic [TW-1:0]      w_beat;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_valid[gi] = s_axis_req_i[gi*BUSW];
    assign w_t[gi]     = s_axis_req_i[gi*BUSW+1 +: TW];
  end

  assign w_space = !r_out_valid || m_axis_resp_i;

  // First valid requester at or after the round-robin pointer, modulo NUM_REQ.
  always_comb begin : p_scan
    logic [IDXW:0] v_sum;
    w_found  = 1'b0;
    w_winner = '0;
    v_sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (IDXW+1)'(k);
      if (v_sum >= (IDXW+1)'(NUM_REQ)) begin
        v_sum = v_sum - (IDXW+1)'(NUM_REQ);
      end
      if (!w_found && w_valid[v_sum[IDXW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = v_sum[IDXW-1:0];
      end
    end
  end

  assign w_sel       = (r_state == ST_LOCKED) ? r_owner : w_winner;
  assign w_sel_valid = (r_state == ST_LOCKED) ? w_valid[w_sel] : w_found;
  assign w_gnt_any   = !rst && ((r_state == ST_LOCKED) || w_found);
  assign w_accept    = w_gnt_any && w_sel_valid && w_space;
  assign w_sel_next  = (w_sel == IDXW'(NUM_REQ - 1)) ? '0 : w_sel + IDXW'(1);

  always_comb begin
    w_beat = w_t[w_sel];
    if (TAG_ID != 0) begin
      w_beat[23:16] = 8'(w_sel);
    end
  end

  for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant_o[gi]       = w_gnt_any && (w_sel == IDXW'(gi));
    assign s_axis_resp_o[gi] = grant_o[gi] && w_space;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_out_valid <= 1'b0;
      r_out_t     <= '0;
    end else begin
      if (w_accept) begin
        r_out_t     <= w_beat;
        r_out_valid <= 1'b1;
        if (w_beat[24]) begin
          r_state  <= ST_IDLE;
          r_rr_ptr <= w_sel_next;
        end else begin
          r_state <= ST_LOCKED;
          r_owner <= w_sel;
        end
      end else if (r_out_valid && m_axis_resp_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_req_o = {r_out_t, r_out_valid};
  assign locked_o     = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_hydra_axis_rr_arbiter.sv
// Scoreboard bench: a 4-port tagging arbiter and a 3-port pass-through arbiter share clock and reset.
module tb_hydra_axis_rr_arbiter;

  localparam int NA = 4;
  localparam int NB = 3;
  localparam int W  = 62;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NA*W-1:0] s_req_a;
  logic [NA-1:0]   s_rdy_a, grant_a;
  logic [W-1:0]    m_req_a;
  logic            m_rdy_a, locked_a;

  logic [NB*W-1:0] s_req_b;
  logic [NB-1:0]   s_rdy_b, grant_b;
  logic [W-1:0]    m_req_b;
  logic            m_rdy_b, locked_b;

  hydra_axis_rr_arbiter #(.NUM_REQ(NA), .TAG_ID(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .s_axis_req_i(s_req_a), .s_axis_resp_o(s_rdy_a),
    .m_axis_req_o(m_req_a), .m_axis_resp_i(m_rdy_a),
    .grant_o(grant_a), .locked_o(locked_a)
  );

  hydra_axis_rr_arbiter #(.NUM_REQ(NB), .TAG_ID(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .s_axis_req_i(s_req_b), .s_axis_resp_o(s_rdy_b),
    .m_axis_req_o(m_req_b), .m_axis_resp_i(m_rdy_b),
    .grant_o(grant_b), .locked_o(locked_b)
  );

  logic [60:0] qa [NA][$];
  logic [60:0] qb [NB][$];
  logic [60:0] exp_a [$];
  logic [60:0] exp_b [$];
  logic [NA-1:0] hold_a = '0;
  logic [NA-1:0] acc_a;
  logic [NB-1:0] acc_b;
  int checks = 0;
  int errors = 0;

  function automatic logic [60:0] mk(input logic [31:0] data, input logic last, input logic [7:0] id);
    return {data, 4'hF, last, id, data[7:0] ^ 8'h5A, ~data[7:0]};
  endfunction

  function automatic logic [60:0] tag(input logic [60:0] t, input int idx);
    logic [60:0] r;
    r = t;
    r[23:16] = 8'(idx);
    return r;
  endfunction

  task automatic drive();
    logic v;
    for (int i = 0; i < NA; i++) begin
      v = !hold_a[i] && (qa[i].size() > 0);
      s_req_a[i*W +: W] = {v ? qa[i][0] : 61'd0, v};
    end
    for (int i = 0; i < NB; i++) begin
      v = (qb[i].size() > 0);
      s_req_b[i*W +: W] = {v ? qb[i][0] : 61'd0, v};
    end
  endtask

  // Sample between edges: record input handshakes and score any output transfer.
  task automatic sample();
    logic [60:0] e;
    @(negedge clk);
    for (int i = 0; i < NA; i++) acc_a[i] = s_req_a[i*W] && s_rdy_a[i];
    for (int i = 0; i < NB; i++) acc_b[i] = s_req_b[i*W] && s_rdy_b[i];
    if (m_req_a[0] && m_rdy_a) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL out_a unexpected beat got %h expected none", m_req_a[61:1]);
      end else begin
        e = exp_a.pop_front();
        if (m_req_a[61:1] !== e) begin
          errors++;
          $display("FAIL out_a beat got %h expected %h", m_req_a[61:1], e);
        end else begin
          $display("A beat data=%h id=%h last=%b", m_req_a[61:30], m_req_a[24:17], m_req_a[25]);
        end
      end
    end
    if (m_req_b[0] && m_rdy_b) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL out_b unexpected beat got %h expected none", m_req_b[61:1]);
      end else begin
        e = exp_b.pop_front();
        if (m_req_b[61:1] !== e) begin
          errors++;
          $display("FAIL out_b beat got %h expected %h", m_req_b[61:1], e);
        end else begin
          $display("B beat data=%h id=%h last=%b", m_req_b[61:30], m_req_b[24:17], m_req_b[25]);
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < NA; i++) if (acc_a[i]) qa[i].delete(0);
    for (int i = 0; i < NB; i++) if (acc_b[i]) qb[i].delete(0);
    drive();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_a.size() > 0 || exp_b.size() > 0 || m_req_a[0] || m_req_b[0]) && n < 60) begin
      sample();
      advance();
      n++;
    end
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0 || m_req_a[0] || m_req_b[0]) begin
      errors++;
      $display("FAIL drain_%s pending a=%0d b=%0d expected 0 0", name, exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_rdy_a = 1'b1; m_rdy_b = 1'b1;
    qa[0].push_back(mk(32'hDEAD, 1'b1, 8'h00));
    qb[1].push_back(mk(32'hBEEF, 1'b1, 8'h00));
    drive();
    sample(); advance();
    sample(); advance();
    sample();
    checks++;
    if (m_req_a !== '0 || locked_a !== 1'b0) begin
      errors++; $display("FAIL reset_out_a got %h/%b expected 0/0", m_req_a, locked_a);
    end
    checks++;
    if (s_rdy_a !== '0 || grant_a !== '0) begin
      errors++; $display("FAIL reset_rdy_a got rdy=%b gnt=%b expected 0", s_rdy_a, grant_a);
    end
    checks++;
    if (m_req_b !== '0 || s_rdy_b !== '0 || grant_b !== '0) begin
      errors++; $display("FAIL reset_b got m=%h rdy=%b gnt=%b expected 0", m_req_b, s_rdy_b, grant_b);
    end
    qa[0].delete(); qb[1].delete();
    advance();
    rst = 1'b0;
    drive();
  endtask

  task automatic test_fairness();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NA; i++) begin
        qa[i].push_back(mk(32'(256*i + k), 1'b1, 8'hEE));
        exp_a.push_back(tag(mk(32'(256*i + k), 1'b1, 8'hEE), i));
      end
    drive();
    for (int c = 0; c <= 12; c++) begin
      logic [NA-1:0] eg;
      sample();
      eg = (c < 12) ? NA'(1 << (c % 4)) : '0;
      checks++;
      if (grant_a !== eg) begin
        errors++; $display("FAIL fair_grant c=%0d got %b expected %b", c, grant_a, eg);
      end
      if (c >= 1) begin
        checks++;
        if (m_req_a[0] !== 1'b1) begin
          errors++; $display("FAIL fair_rate c=%0d got tvalid=%b expected 1", c, m_req_a[0]);
        end
      end
      advance();
    end
    drain("fair");
  endtask

  task automatic test_packet_lock();
    for (int k = 0; k < 4; k++) begin
      qa[1].push_back(mk(32'h11 + 32'(k), k == 3, 8'h01));
      exp_a.push_back(tag(mk(32'h11 + 32'(k), k == 3, 8'h01), 1));
    end
    exp_a.push_back(tag(mk(32'hA2, 1'b1, 8'h22), 2));
    exp_a.push_back(tag(mk(32'hA0, 1'b1, 8'h20), 0));
    drive();
    sample();
    checks++;
    if (grant_a !== 4'b0010 || locked_a !== 1'b0) begin
      errors++; $display("FAIL lock_start got gnt=%b lock=%b expected 0010/0", grant_a, locked_a);
    end
    advance();
    qa[0].push_back(mk(32'hA0, 1'b1, 8'h20));
    qa[2].push_back(mk(32'hA2, 1'b1, 8'h22));
    drive();
    for (int c = 1; c <= 5; c++) begin
      logic [NA-1:0] eg;
      sample();
      eg = (c <= 3) ? 4'b0010 : (c == 4) ? 4'b0100 : 4'b0001;
      checks++;
      if (grant_a !== eg || locked_a !== (c <= 3)) begin
        errors++; $display("FAIL lock_grant c=%0d got gnt=%b lock=%b expected %b/%b", c, grant_a, locked_a, eg, c <= 3);
      end
      if (c <= 3) begin
        checks++;
        if (s_rdy_a[0] !== 1'b0 || s_rdy_a[2] !== 1'b0) begin
          errors++; $display("FAIL lock_stall c=%0d got rdy=%b expected x0x0", c, s_rdy_a);
        end
      end
      advance();
    end
    drain("lock");
  endtask

  task automatic test_backpressure();
    logic [61:0] held;
    for (int k = 0; k < 4; k++) begin
      qa[3].push_back(mk(32'h31 + 32'(k), k == 3, 8'h03));
      exp_a.push_back(tag(mk(32'h31 + 32'(k), k == 3, 8'h03), 3));
    end
    drive();
    sample(); advance();
    sample(); advance();
    m_rdy_a = 1'b0;
    held = {tag(mk(32'h32, 1'b0, 8'h03), 3), 1'b1};
    for (int c = 0; c < 5; c++) begin
      sample();
      checks++;
      if (m_req_a !== held) begin
        errors++; $display("FAIL bp_hold c=%0d got %h expected %h", c, m_req_a, held);
      end
      checks++;
      if (s_rdy_a !== '0 || grant_a !== 4'b1000) begin
        errors++; $display("FAIL bp_rdy c=%0d got rdy=%b gnt=%b expected 0000/1000", c, s_rdy_a, grant_a);
      end
      advance();
    end
    m_rdy_a = 1'b1;
    drain("bp");
  endtask

  task automatic test_owner_bubble();
    for (int k = 0; k < 4; k++) begin
      qa[0].push_back(mk(32'h01 + 32'(k), k == 3, 8'h10));
      exp_a.push_back(tag(mk(32'h01 + 32'(k), k == 3, 8'h10), 0));
    end
    qa[3].push_back(mk(32'h3F, 1'b1, 8'h30));
    exp_a.push_back(tag(mk(32'h3F, 1'b1, 8'h30), 3));
    drive();
    sample(); advance();
    sample(); advance();
    hold_a[0] = 1'b1;
    drive();
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (s_rdy_a[3] !== 1'b0 || grant_a !== 4'b0001 || locked_a !== 1'b1) begin
        errors++; $display("FAIL bubble c=%0d got rdy=%b gnt=%b lock=%b expected 0xxx/0001/1", c, s_rdy_a, grant_a, locked_a);
      end
      advance();
    end
    hold_a[0] = 1'b0;
    drive();
    drain("bubble");
  endtask

  task automatic test_wrap();
    qb[2].push_back(mk(32'hB2, 1'b1, 8'hA5));
    exp_b.push_back(mk(32'hB2, 1'b1, 8'hA5));
    drive();
    sample();
    checks++;
    if (grant_b !== 3'b100) begin
      errors++; $display("FAIL wrap_first got gnt=%b expected 100", grant_b);
    end
    advance();
    qb[1].push_back(mk(32'hB1, 1'b1, 8'hA5));
    qb[0].push_back(mk(32'hB0, 1'b1, 8'hA5));
    exp_b.push_back(mk(32'hB0, 1'b1, 8'hA5));
    exp_b.push_back(mk(32'hB1, 1'b1, 8'hA5));
    drive();
    sample();
    checks++;
    if (grant_b !== 3'b001) begin
      errors++; $display("FAIL wrap_next got gnt=%b expected 001", grant_b);
    end
    advance();
    drain("wrap");
  endtask

  task automatic test_reset_mid_packet();
    for (int k = 0; k < 4; k++) qa[2].push_back(mk(32'h21 + 32'(k), k == 3, 8'h02));
    exp_a.push_back(tag(mk(32'h21, 1'b0, 8'h02), 2));
    exp_a.push_back(tag(mk(32'h22, 1'b0, 8'h02), 2));
    drive();
    sample(); advance();
    sample(); advance();
    rst = 1'b1;
    drive();
    sample();
    checks++;
    if (s_rdy_a !== '0 || grant_a !== '0) begin
      errors++; $display("FAIL rstmid_comb got rdy=%b gnt=%b expected 0/0", s_rdy_a, grant_a);
    end
    advance();
    qa[2].delete();
    qa[1].push_back(mk(32'h1B, 1'b1, 8'h11));
    qa[3].push_back(mk(32'h3B, 1'b1, 8'h33));
    exp_a.push_back(tag(mk(32'h1B, 1'b1, 8'h11), 1));
    exp_a.push_back(tag(mk(32'h3B, 1'b1, 8'h33), 3));
    drive();
    sample();
    checks++;
    if (m_req_a[0] !== 1'b0 || s_rdy_a !== '0 || locked_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got v=%b rdy=%b lock=%b expected 0/0/0", m_req_a[0], s_rdy_a, locked_a);
    end
    advance();
    rst = 1'b0;
    drive();
    sample();
    checks++;
    if (grant_a !== 4'b0010) begin
      errors++; $display("FAIL rstmid_winner got gnt=%b expected 0010", grant_a);
    end
    advance();
    drain("rstmid");
  endtask

  initial begin
    s_req_a = '0; s_req_b = '0; m_rdy_a = 1'b1; m_rdy_b = 1'b1;
    test_reset();
    test_fairness();
    test_packet_lock();
    test_backpressure();
    test_owner_bubble();
    test_wrap();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
